exp_taylor_seq: RTL and testbench

- Sequencer that evaluates e^x in Q16 fixed point by Taylor series, using one shared external `booth` multiplier through a start/done handshake.
- Owns the term recurrence, the 1/k reciprocal constants, the accumulator and early termination.
- Sits between a requesting client (start/x/done) and the `booth` multiplier instance, replacing ad-hoc result-triggered sequencing with a clocked FSM.

---
 rtl/exp_pkg.sv | 35 +++
 rtl/exp_taylor_seq.sv | 125 ++++++++++++
 tb/tb_exp_taylor_seq.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exp_pkg.sv
// Shared constants for the Q16 Taylor-series e^x sequencer: widths,
// the Q16 value of one, the 1/k reciprocal ROM and the FSM state codes.
package exp_pkg;

  localparam int Q_FRAC = 16;   // fractional bits of the Q16 format
  localparam int OPER_W = 17;   // unsigned Q16 operand, x < 2.0
  localparam int PROD_W = 34;   // full multiplier product width
  localparam int ACC_W  = 32;   // accumulator / result width
  localparam int K_W    = 5;    // series index, holds 0..16

  localparam logic [ACC_W-1:0] ONE = 32'd65536;

  // round(65536/k) for k = 2..16; other slots are never addressed in a run.
  // The table is 32 deep so that any K_W-bit index lands on a defined entry.
  localparam logic [OPER_W-1:0] RECIP [32] = '{
    17'd0,     17'd65536, 17'd32768, 17'd21845,
    17'd16384, 17'd13107, 17'd10923, 17'd9362,
    17'd8192,  17'd7282,  17'd6554,  17'd5958,
    17'd5461,  17'd5041,  17'd4681,  17'd4369,
    17'd4096,  17'd0,     17'd0,     17'd0,
    17'd0,     17'd0,     17'd0,     17'd0,
    17'd0,     17'd0,     17'd0,     17'd0,
    17'd0,     17'd0,     17'd0,     17'd0
  };

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_ISSUE_R = 3'd1;
  localparam state_t S_WAIT_R  = 3'd2;
  localparam state_t S_ISSUE_X = 3'd3;
  localparam state_t S_WAIT_X  = 3'd4;
  localparam state_t S_FINISH  = 3'd5;

endpackage

// File: rtl/exp_taylor_seq.sv
// e^x in unsigned Q16 by Taylor series. Each new term is formed as
// term * (1/k) followed by * x, both through one external multiplier
// reached over a start/done handshake. Dividing first keeps every
// intermediate term below 2.0 so it always fits the operand width.
module exp_taylor_seq
  import exp_pkg::*;
#(
  parameter int N_TERMS = 9,
  parameter int W       = OPER_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     x_in,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result,
  output logic             mul_start,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  input  logic             mul_done,
  input  logic [2*W-1:0]   mul_p
);

  localparam logic [K_W-1:0] K_LAST = K_W'(N_TERMS);
  localparam bit             SINGLE = (N_TERMS == 1);

  state_t           state;
  logic [W-1:0]     xr;
  logic [W-1:0]     term;
  logic [W-1:0]     t;
  logic [ACC_W-1:0] acc;
  logic [K_W-1:0]   k;
  logic             unused_prod;

  // Truncate the product back to Q16; the integer overflow bit and the
  // discarded fraction bits are intentionally dropped.
  assign t           = mul_p[Q_FRAC +: W];
  assign unused_prod = ^{mul_p[2*W-1:Q_FRAC+W], mul_p[Q_FRAC-1:0]};

  // Sequencer: owns the term recurrence, accumulator and handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      xr        <= '0;
      term      <= '0;
      acc       <= '0;
      k         <= '0;
    end else begin
      mul_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            xr    <= x_in;
            acc   <= ONE + ACC_W'(x_in);
            term  <= x_in;
            k     <= K_W'(2);
            busy  <= 1'b1;
            // x == 0 gives exactly 1.0; a single-term series needs no multiply.
            state <= ((x_in == '0) || SINGLE) ? S_FINISH : S_ISSUE_R;
          end
        end

        S_ISSUE_R: begin
          mul_start <= 1'b1;
          mul_a     <= term;
          mul_b     <= W'(RECIP[k]);
          state     <= S_WAIT_R;
        end

        S_WAIT_R: begin
          if (mul_done) begin
            // A zero quotient makes every later term zero, so skip the x multiply.
            if (t == '0) begin
              state <= S_FINISH;
            end else begin
              term  <= t;
              state <= S_ISSUE_X;
            end
          end
        end

        S_ISSUE_X: begin
          mul_start <= 1'b1;
          mul_a     <= term;
          mul_b     <= xr;
          state     <= S_WAIT_X;
        end

        S_WAIT_X: begin
          if (mul_done) begin
            acc  <= acc + ACC_W'(t);
            term <= t;
            if ((t == '0) || (k == K_LAST)) begin
              state <= S_FINISH;
            end else begin
              k     <= k + K_W'(1);
              state <= S_ISSUE_R;
            end
          end
        end

        S_FINISH: begin
          result <= acc;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exp_taylor_seq.sv
// Bench for exp_taylor_seq: three instances (N_TERMS = 9, 4, 1), each with
// a behavioural multiplier of programmable latency. Expected results are
// queued when a request is driven and compared when done appears.
module tb_exp_taylor_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start;
  logic [16:0] x_in;

  logic [2:0]  busy_v, done_v, mstart_v;
  logic [31:0] result_v [3];
  logic [16:0] mula_v [3];
  logic [16:0] mulb_v [3];
  int          nstart_v [3];
  int          stab_v [3];
  int          bd_v [3];

  int          lat_fix;
  bit          rnd_lat;
  int          inj_cnt [3];

  int          total = 0;
  int          bad   = 0;
  longint      q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NT = (g == 0) ? 9 : ((g == 1) ? 4 : 1);

    logic        busy_l, done_l, mstart_l;
    logic [31:0] result_l;
    logic [16:0] mula_l, mulb_l;
    logic        mdone = 1'b0;
    logic [33:0] mp    = '0;
    bit          pend  = 1'b0;
    int          cnt   = 0;
    int          nstart = 0;
    int          stab   = 0;
    int          bd     = 0;
    int          inj_seen = 0;
    logic [16:0] a = '0, b = '0;

    exp_taylor_seq #(.N_TERMS(NT), .W(17)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start[g]),
      .x_in      (x_in),
      .busy      (busy_l),
      .done      (done_l),
      .result    (result_l),
      .mul_start (mstart_l),
      .mul_a     (mula_l),
      .mul_b     (mulb_l),
      .mul_done  (mdone),
      .mul_p     (mp)
    );

    assign busy_v[g]   = busy_l;
    assign done_v[g]   = done_l;
    assign mstart_v[g] = mstart_l;
    assign result_v[g] = result_l;
    assign mula_v[g]   = mula_l;
    assign mulb_v[g]   = mulb_l;
    assign nstart_v[g] = nstart;
    assign stab_v[g]   = stab;
    assign bd_v[g]     = bd;

    // Behavioural multiplier, evaluated on the falling edge.
    always @(negedge clk) begin
      if (!rst_n) begin
        pend  = 1'b0;
        mdone = 1'b0;
        cnt   = 0;
      end else begin
        mdone = 1'b0;
        if (busy_l && done_l) bd++;
        if (mstart_l) nstart++;
        if (pend) begin
          if ((mula_l !== a) || (mulb_l !== b)) stab++;
          cnt--;
          if (cnt <= 0) begin
            mdone = 1'b1;
            mp    = 34'(a) * 34'(b);
            pend  = 1'b0;
          end
        end else if (mstart_l) begin
          pend = 1'b1;
          a    = mula_l;
          b    = mulb_l;
          cnt  = rnd_lat ? int'($urandom_range(1, 40)) : lat_fix;
        end else if (inj_seen != inj_cnt[g]) begin
          inj_seen = inj_cnt[g];
          mdone    = 1'b1;
          mp       = 34'h0_8000_0000;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Golden model of the truncating recurrence; reciprocals computed by rounding division.
  function automatic longint gold(input longint x, input int n, output int nm);
    longint acc, term, p, t, r;
    nm   = 0;
    acc  = 65536 + x;
    term = x;
    if (x == 0 || n == 1) return acc;
    for (int kk = 2; kk <= n; kk++) begin
      r = (65536 + kk / 2) / kk;
      p = term * r;
      t = (p >> 16) & 64'h1FFFF;
      nm++;
      if (t == 0) return acc;
      term = t;
      p = term * x;
      t = (p >> 16) & 64'h1FFFF;
      nm++;
      acc  = acc + t;
      term = t;
      if (t == 0) return acc;
    end
    return acc;
  endfunction

  task automatic go(input int idx, input logic [16:0] x);
    @(negedge clk);
    x_in       = x;
    start[idx] = 1'b1;
    @(negedge clk);
    start[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx, input string tag, input int nm, input int s0);
    int     c;
    longint expv;
    c = 0;
    while (!done_v[idx] && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_done"}, 64'(done_v[idx]), 64'd1);
    expv = q.pop_front();
    chk(tag, 64'(result_v[idx]), 64'(expv));
    if (nm >= 0) chk({tag, "_nmul"}, 64'(nstart_v[idx] - s0), 64'(nm));
  endtask

  task automatic run(input int idx, input logic [16:0] x, input longint expv,
                     input int nm, input string tag);
    int s0;
    s0 = nstart_v[idx];
    q.push_back(expv);
    go(idx, x);
    chk({tag, "_busy"}, 64'(busy_v[idx]), 64'd1);
    wait_done(idx, tag, nm, s0);
  endtask

  initial begin
    int     s0, s1, c, nm;
    longint g;

    rst_n   = 1'b0;
    start   = '0;
    x_in    = '0;
    lat_fix = 3;
    rnd_lat = 1'b0;
    for (int i = 0; i < 3; i++) inj_cnt[i] = 0;

    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({busy_v[0], done_v[0], mstart_v[0], mula_v[0], mulb_v[0]}), 64'd0);
    chk("reset_result", 64'(result_v[0]), 64'd0);
    rst_n = 1'b1;

    // Test 1: x = 0
    run(0, 17'd0, 65536, 0, "t1_x0");

    // Test 2: x = 1.0, 17-cycle multiplier
    lat_fix = 17;
    run(0, 17'd65536, 178140, 15, "t2_x1");

    // Test 3: shorter series
    lat_fix = 3;
    run(1, 17'd65536, 177492, 6, "t3_n4");
    run(2, 17'd65536, 131072, 0, "t3_n1");

    // Test 4: start while busy is ignored; stray mul_done in IDLE is ignored
    s0 = nstart_v[0];
    q.push_back(178140);
    go(0, 17'd65536);
    repeat (5) @(negedge clk);
    x_in     = 17'd32768;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    x_in     = '0;
    wait_done(0, "t4_busy_start", 15, s0);
    s1 = nstart_v[0];
    inj_cnt[0]++;
    repeat (8) @(negedge clk);
    chk("t4_idle_inj_ctrl", 64'({busy_v[0], done_v[0], mstart_v[0]}), 64'd0);
    chk("t4_idle_inj_result", 64'(result_v[0]), 64'd178140);
    chk("t4_idle_inj_nmul", 64'(nstart_v[0] - s1), 64'd0);

    // Test 5: reset during WAIT_X
    lat_fix = 17;
    s0 = nstart_v[0];
    go(0, 17'd65536);
    c = 0;
    while (nstart_v[0] < s0 + 2 && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("t5_reached_wait_x", 64'(nstart_v[0] - s0), 64'd2);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_ctrl", 64'({busy_v[0], done_v[0], mstart_v[0], mula_v[0], mulb_v[0]}), 64'd0);
    chk("t5_async_result", 64'(result_v[0]), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s1 = nstart_v[0];
    inj_cnt[0]++;
    repeat (10) @(negedge clk);
    chk("t5_late_done_ctrl", 64'({busy_v[0], done_v[0], mstart_v[0]}), 64'd0);
    chk("t5_late_done_result", 64'(result_v[0]), 64'd0);
    chk("t5_late_done_nmul", 64'(nstart_v[0] - s1), 64'd0);
    run(0, 17'd65536, 178140, 15, "t5_fresh");

    // Test 6: random multiplier latency
    rnd_lat = 1'b1;
    g = gold(32768, 9, nm);
    run(0, 17'd32768, g, nm, "t6_half");
    g = gold(131071, 9, nm);
    run(0, 17'd131071, g, nm, "t6_max");
    g = gold(1, 9, nm);
    run(0, 17'd1, g, nm, "t6_tiny");
    g = gold(98304, 4, nm);
    run(1, 17'd98304, g, nm, "t6_n4");

    chk("operand_stable", 64'(stab_v[0] + stab_v[1] + stab_v[2]), 64'd0);
    chk("busy_done_excl", 64'(bd_v[0] + bd_v[1] + bd_v[2]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
